// File: rtl/rf_pkg.sv
// Shared defaults, queue entry layout and queue-operation encoding for the
// register-file write controller.
package rf_pkg;

  localparam int unsigned RF_NREG  = 32;
  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_DEPTH = 2;

  typedef struct packed {
    logic [4:0]          addr;
    logic [RF_WIDTH-1:0] data;
  } wq_entry_t;

  // Bit 1 = push, bit 0 = pop.
  typedef enum logic [1:0] {
    WQ_IDLE     = 2'b00,
    WQ_POP      = 2'b01,
    WQ_PUSH     = 2'b10,
    WQ_PUSH_POP = 2'b11
  } wq_op_e;

  function automatic int unsigned rf_wrap_inc(input int unsigned ptr,
                                              input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rf_addr_decode.sv
// 5-bit register address to NREG-wide one-hot decode, all-zero when disabled.
module rf_addr_decode #(
  parameter int unsigned NREG = 32
) (
  input  logic [4:0]      i_addr,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      o_onehot[i] = i_en && (i_addr == 5'(i));
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write queue feeding a registered one-hot bank write port.
// Optional macro RF_WRITE_BYPASS_EN adds byp_data_a/byp_data_b forwarding outputs.
module regfile_write_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned NREG  = RF_NREG,
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned DEPTH = RF_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid,
  input  logic [4:0]       req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  input  logic             hold,
  output logic [NREG-1:0]  bank_we,
  output logic [WIDTH-1:0] bank_wdata,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic             rd_pend_a,
  output logic             rd_pend_b,
  output logic [1:0]       count
`ifdef RF_WRITE_BYPASS_EN
  ,
  output logic [WIDTH-1:0] byp_data_a,
  output logic [WIDTH-1:0] byp_data_b
`endif
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  DEPTH_C = 2'(DEPTH);

  wq_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [1:0]       r_count;
  logic [NREG-1:0]  r_bank_we;
  logic [WIDTH-1:0] r_bank_wdata;
  logic [4:0]       r_out_addr;

  logic             w_push;
  logic             w_pop;
  wq_op_e           w_op;
  logic [1:0]       w_count_nxt;
  wq_entry_t        w_head;
  wq_entry_t        w_new;
  logic [NREG-1:0]  w_dec;
  logic             w_qhit_a;
  logic             w_qhit_b;
  logic             w_ohit_a;
  logic             w_ohit_b;

  // Ready depends on count only, so a full queue never accepts even if it pops.
  assign req_ready = (r_count < DEPTH_C);
  assign w_push    = req_valid && req_ready && (req_addr != 5'd0);
  assign w_pop     = !hold && (r_count != 2'd0);
  assign w_head    = r_mem[r_rptr];
  assign w_new     = '{addr: req_addr, data: RF_WIDTH'(req_data)};

  always_comb begin
    w_op        = wq_op_e'({w_push, w_pop});
    w_count_nxt = r_count;
    case (w_op)
      WQ_PUSH:     w_count_nxt = r_count + 2'd1;
      WQ_POP:      w_count_nxt = r_count - 2'd1;
      WQ_PUSH_POP: w_count_nxt = r_count;
      default:     w_count_nxt = r_count;
    endcase
  end

  rf_addr_decode #(
    .NREG (NREG)
  ) u_dec (
    .i_addr   (w_head.addr),
    .i_en     (w_pop),
    .o_onehot (w_dec)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_bank_we    <= '0;
      r_bank_wdata <= '0;
      r_out_addr   <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_bank_we <= w_dec;
      if (w_push) begin
        r_wptr <= PW'(rf_wrap_inc(32'(r_wptr), DEPTH));
      end
      if (w_pop) begin
        r_rptr       <= PW'(rf_wrap_inc(32'(r_rptr), DEPTH));
        r_bank_wdata <= WIDTH'(w_head.data);
        r_out_addr   <= w_head.addr;
      end
    end
  end

  // Walk the live entries oldest to youngest starting at the read pointer.
  always_comb begin : pend_lookup
    logic [PW-1:0] idx;
    idx      = '0;
    w_qhit_a = 1'b0;
    w_qhit_b = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = PW'((32'(r_rptr) + k) % DEPTH);
      if (k < 32'(r_count)) begin
        if (r_mem[idx].addr == rd_addr_a) w_qhit_a = 1'b1;
        if (r_mem[idx].addr == rd_addr_b) w_qhit_b = 1'b1;
      end
    end
  end

  assign w_ohit_a  = (r_bank_we != '0) && (r_out_addr == rd_addr_a);
  assign w_ohit_b  = (r_bank_we != '0) && (r_out_addr == rd_addr_b);
  assign rd_pend_a = (rd_addr_a != 5'd0) && (w_qhit_a || w_ohit_a);
  assign rd_pend_b = (rd_addr_b != 5'd0) && (w_qhit_b || w_ohit_b);

`ifdef RF_WRITE_BYPASS_EN
  // Later matches overwrite earlier ones, so the youngest queued write wins.
  always_comb begin : byp_lookup
    logic [PW-1:0]    idx;
    logic             qa;
    logic             qb;
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] db;
    idx = '0;
    qa  = 1'b0;
    qb  = 1'b0;
    da  = '0;
    db  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = PW'((32'(r_rptr) + k) % DEPTH);
      if (k < 32'(r_count)) begin
        if (r_mem[idx].addr == rd_addr_a) begin
          qa = 1'b1;
          da = WIDTH'(r_mem[idx].data);
        end
        if (r_mem[idx].addr == rd_addr_b) begin
          qb = 1'b1;
          db = WIDTH'(r_mem[idx].data);
        end
      end
    end
    byp_data_a = '0;
    byp_data_b = '0;
    if (rd_pend_a) byp_data_a = qa ? da : r_bank_wdata;
    if (rd_pend_b) byp_data_b = qb ? db : r_bank_wdata;
  end
`endif

  assign bank_we    = r_bank_we;
  assign bank_wdata = r_bank_wdata;
  assign count      = r_count;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed self-checking bench for regfile_write_ctrl (default parameters).
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        req_ready;
  logic        hold;
  logic [31:0] bank_we;
  logic [31:0] bank_wdata;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        rd_pend_a;
  logic        rd_pend_b;
  logic [1:0]  count;
`ifdef RF_WRITE_BYPASS_EN
  logic [31:0] byp_data_a;
  logic [31:0] byp_data_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .bank_we    (bank_we),
    .bank_wdata (bank_wdata),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_pend_a  (rd_pend_a),
    .rd_pend_b  (rd_pend_b),
    .count      (count)
`ifdef RF_WRITE_BYPASS_EN
    ,
    .byp_data_a (byp_data_a),
    .byp_data_b (byp_data_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    hold = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_we", 64'(bank_we), 64'd0);
    chk("rst_wdata", 64'(bank_wdata), 64'd0);
    chk("rst_pend_a", 64'(rd_pend_a), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);

    // Release reset and present a request for the very first edge.
    #10;
    clr = 1'b0; req_valid = 1'b1; req_addr = 5'd5; req_data = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    chk("r5_count", 64'(count), 64'd1);
    chk("r5_we_early", 64'(bank_we), 64'd0);
    chk("r5_pend_q", 64'(rd_pend_a), 64'd1);
    tick();
    chk("r5_we", 64'(bank_we), 64'h20);
    chk("r5_wdata", 64'(bank_wdata), 64'hDEADBEEF);
    chk("r5_count0", 64'(count), 64'd0);
    chk("r5_pend_out", 64'(rd_pend_b), 64'd1);
    tick();
    chk("r5_we_off", 64'(bank_we), 64'd0);
    chk("r5_wdata_keep", 64'(bank_wdata), 64'hDEADBEEF);
    chk("r5_pend_off", 64'(rd_pend_a), 64'd0);

    // Write to r0: handshake only.
    req_valid = 1'b1; req_addr = 5'd0; req_data = 32'h1234;
    #1;
    chk("r0_ready", 64'(req_ready), 64'd1);
    tick();
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_ready2", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    tick();
    chk("r0_we", 64'(bank_we), 64'd0);
    chk("r0_wdata", 64'(bank_wdata), 64'hDEADBEEF);

    // Fill under hold, then drain; a request offered while full is refused.
    hold = 1'b1; req_valid = 1'b1; req_addr = 5'd3; req_data = 32'h33;
    tick();
    chk("h_count1", 64'(count), 64'd1);
    req_addr = 5'd4; req_data = 32'h44;
    tick();
    chk("h_count2", 64'(count), 64'd2);
    chk("h_ready", 64'(req_ready), 64'd0);
    chk("h_we", 64'(bank_we), 64'd0);
    req_addr = 5'd12; req_data = 32'hCC;
    rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    #1;
    chk("h_pend_a", 64'(rd_pend_a), 64'd1);
    chk("h_pend_b", 64'(rd_pend_b), 64'd1);
    hold = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("d_we_r3", 64'(bank_we), 64'h8);
    chk("d_wdata_r3", 64'(bank_wdata), 64'h33);
    chk("d_count1", 64'(count), 64'd1);
    tick();
    chk("d_we_r4", 64'(bank_we), 64'h10);
    chk("d_wdata_r4", 64'(bank_wdata), 64'h44);
    chk("d_count0", 64'(count), 64'd0);
    tick();
    chk("d_we_none", 64'(bank_we), 64'd0);
    chk("d_count_end", 64'(count), 64'd0);

    // Simultaneous push and pop keeps count and order.
    hold = 1'b1; req_valid = 1'b1; req_addr = 5'd10; req_data = 32'hA0;
    tick();
    hold = 1'b0; req_addr = 5'd11; req_data = 32'hB1;
    tick();
    req_valid = 1'b0;
    chk("pp_count", 64'(count), 64'd1);
    chk("pp_we_r10", 64'(bank_we), 64'h400);
    chk("pp_wdata_r10", 64'(bank_wdata), 64'hA0);
    tick();
    chk("pp_we_r11", 64'(bank_we), 64'h800);
    chk("pp_wdata_r11", 64'(bank_wdata), 64'hB1);
    chk("pp_count0", 64'(count), 64'd0);

    // Pending lookup on r7 through queue then output register.
    hold = 1'b1; req_valid = 1'b1; req_addr = 5'd7; req_data = 32'h77;
    rd_addr_a = 5'd7; rd_addr_b = 5'd0;
    tick();
    req_valid = 1'b0;
    chk("p7_pend_a", 64'(rd_pend_a), 64'd1);
    chk("p7_pend_b", 64'(rd_pend_b), 64'd0);
`ifdef RF_WRITE_BYPASS_EN
    chk("p7_byp_a", 64'(byp_data_a), 64'h77);
    chk("p7_byp_b", 64'(byp_data_b), 64'd0);
`endif
    hold = 1'b0;
    tick();
    chk("p7_we", 64'(bank_we), 64'h80);
    chk("p7_pend_out", 64'(rd_pend_a), 64'd1);
`ifdef RF_WRITE_BYPASS_EN
    chk("p7_byp_out", 64'(byp_data_a), 64'h77);
`endif
    hold = 1'b1;
    tick();
    chk("p7_we_off", 64'(bank_we), 64'd0);
    chk("p7_pend_off", 64'(rd_pend_a), 64'd0);

    // Two queued writes to r9: youngest data forwards.
    rd_addr_a = 5'd9; rd_addr_b = 5'd9;
    req_valid = 1'b1; req_addr = 5'd9; req_data = 32'h1;
    tick();
    req_data = 32'h2;
    tick();
    req_valid = 1'b0;
    chk("r9_count", 64'(count), 64'd2);
    chk("r9_pend", 64'(rd_pend_a), 64'd1);
`ifdef RF_WRITE_BYPASS_EN
    chk("r9_byp", 64'(byp_data_a), 64'h2);
`endif

    // Mid-cycle clear with a full queue and a coincident request.
    #3;
    clr = 1'b1;
    #1;
    chk("c_count", 64'(count), 64'd0);
    chk("c_we", 64'(bank_we), 64'd0);
    chk("c_wdata", 64'(bank_wdata), 64'd0);
    chk("c_pend", 64'(rd_pend_a), 64'd0);
    req_valid = 1'b1; req_addr = 5'd13; req_data = 32'hDD;
    tick();
    chk("c_count_edge", 64'(count), 64'd0);
    clr = 1'b0; req_valid = 1'b0; hold = 1'b0; rd_addr_a = 5'd13;
    tick();
    chk("c_we_after1", 64'(bank_we), 64'd0);
    chk("c_count_after", 64'(count), 64'd0);
    chk("c_pend13", 64'(rd_pend_a), 64'd0);
    tick();
    chk("c_we_after2", 64'(bank_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
